// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer.
// Contents:
//   SB_DEPTH_DEF  default entry count
//   LD_WORD_MASK  byte mask of a load lookup (loads always cover a full word)
//   sb_entry_t    one buffered store: byte address, lane-aligned data, byte strobes
//   word_overlap  same-word compare plus strobe overlap against the load mask
package store_buffer_pkg;

   localparam int         SB_DEPTH_DEF = 8;
   localparam logic [3:0] LD_WORD_MASK = 4'b1111;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  wstrb;
   } sb_entry_t;

   // A load conflicts when it hits the same 32-bit word and shares at least one byte.
   function automatic logic word_overlap(input logic [31:0] st_addr,
                                         input logic [3:0]  st_wstrb,
                                         input logic [31:0] ld_addr);
      return (st_addr[31:2] == ld_addr[31:2]) &&
             ((st_wstrb & LD_WORD_MASK) != 4'b0000);
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of every store-buffer signal except clock and reset.
//   master : pipeline / dcache side (drives stores, commits, flush, dcache ready, load lookup)
//   slave  : the store buffer itself
interface store_buffer_if;

   logic        flush;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_wstrb;
   logic        st_ex;
   logic        sb_allowin;
   logic        commit_store1_valid;
   logic        commit_store2_valid;
   logic        dcache_wr_req;
   logic [31:0] dcache_wr_addr;
   logic [31:0] dcache_wr_data;
   logic [3:0]  dcache_wr_wstrb;
   logic        dcache_wr_ready;
   logic [31:0] ld_addr;
   logic        ld_conflict;
   logic        sb_empty;

   modport master (
      output flush, st_valid, st_addr, st_data, st_wstrb, st_ex,
      output commit_store1_valid, commit_store2_valid, dcache_wr_ready, ld_addr,
      input  sb_allowin, dcache_wr_req, dcache_wr_addr, dcache_wr_data, dcache_wr_wstrb,
      input  ld_conflict, sb_empty
   );

   modport slave (
      input  flush, st_valid, st_addr, st_data, st_wstrb, st_ex,
      input  commit_store1_valid, commit_store2_valid, dcache_wr_ready, ld_addr,
      output sb_allowin, dcache_wr_req, dcache_wr_addr, dcache_wr_data, dcache_wr_wstrb,
      output ld_conflict, sb_empty
   );

endinterface

// File: rtl/store_buffer_cam_match.sv
// Parallel load-vs-store match over the occupied region of the entry ring.
// Ports:
//   entries  all entry registers
//   head_idx ring index of the oldest entry
//   count    occupied entries (tail - head), IDX_W+1 bits so a full ring is representable
//   ld_addr  load address being looked up
//   hit      some occupied entry shares a word and a byte with the load
module sb_cam_match
   import store_buffer_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH_DEF,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  sb_entry_t        entries [DEPTH],
   input  logic [IDX_W-1:0] head_idx,
   input  logic [IDX_W:0]   count,
   input  logic [31:0]      ld_addr,
   output logic             hit
);

   logic [DEPTH-1:0] in_region_s;
   logic [DEPTH-1:0] match_s;

   // Per-entry occupancy (distance from head below count) and word/strobe match.
   always_comb begin
      in_region_s = '0;
      match_s     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         in_region_s[i] = ({1'b0, IDX_W'(i) - head_idx} < count);
         match_s[i]     = word_overlap(entries[i].addr, entries[i].wstrb, ld_addr);
      end
   end

   assign hit = |(in_region_s & match_s);

endmodule

// File: rtl/store_buffer_chk.sv
// Upstream protocol checks for the store buffer; simulation only, no logic.
// Ports:
//   clk, reset            block clock / synchronous reset
//   st_valid, sb_allowin  enqueue handshake
//   commit1, commit2      commit pulses from commit_stage
//   spec_cnt              current speculative entry count (tail - cmt)
module store_buffer_chk #(
   parameter int PTR_W = 4
) (
   input logic             clk,
   input logic             reset,
   input logic             st_valid,
   input logic             sb_allowin,
   input logic             commit1,
   input logic             commit2,
   input logic [PTR_W-1:0] spec_cnt
);

   a_no_store_when_full: assert property (@(posedge clk) disable iff (reset)
      !(st_valid && !sb_allowin));

   a_store2_needs_store1: assert property (@(posedge clk) disable iff (reset)
      !(commit2 && !commit1));

   a_commit_within_spec: assert property (@(posedge clk) disable iff (reset)
      (PTR_W'({1'b0, commit1} + {1'b0, commit2}) <= spec_cnt));

endmodule

// File: rtl/store_buffer.sv
// Post-execute store queue: holds executed stores speculatively until commit,
// discards uncommitted ones on flush, drains committed ones in order to the dcache
// and flags loads that overlap any buffered store.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   sb     store_buffer_if.slave (enqueue, commit, flush, dcache write, load lookup, status)
// Ring pointers carry a wrap bit: [head,cmt) committed, [cmt,tail) speculative.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter  int SB_DEPTH = SB_DEPTH_DEF,
   localparam int PTR_W    = $clog2(SB_DEPTH) + 1
) (
   input logic        clk,
   input logic        reset,
   store_buffer_if.slave sb
);

   localparam int               IDX_W   = PTR_W - 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(SB_DEPTH);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] cmt_q,  cmt_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   sb_entry_t        entries_q [SB_DEPTH];
   sb_entry_t        entries_d [SB_DEPTH];

   logic [PTR_W-1:0] count_s;
   logic [PTR_W-1:0] spec_cnt_s;
   logic [PTR_W-1:0] cmt_add_s;
   logic             allowin_s;
   logic             enq_s;
   logic             drain_s;
   sb_entry_t        head_entry_s;

   assign count_s      = tail_q - head_q;
   assign spec_cnt_s   = tail_q - cmt_q;
   assign cmt_add_s    = PTR_W'({1'b0, sb.commit_store1_valid} + {1'b0, sb.commit_store2_valid});
   assign allowin_s    = (count_s < PTR_MAX);
   assign enq_s        = sb.st_valid && !sb.st_ex && allowin_s && !sb.flush;
   assign head_entry_s = entries_q[head_q[IDX_W-1:0]];
   assign drain_s      = (head_q != cmt_q) && sb.dcache_wr_ready;

   // Next-state for the three pointers and the entry array.
   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      cmt_d     = cmt_q;
      tail_d    = tail_q;

      if (enq_s) begin
         entries_d[tail_q[IDX_W-1:0]] = '{addr: sb.st_addr, data: sb.st_data, wstrb: sb.st_wstrb};
      end else begin
         entries_d = entries_q;
      end

      // Over-commit is illegal upstream; clamp so cmt never passes tail.
      if (cmt_add_s > spec_cnt_s) begin
         cmt_d = tail_q;
      end else begin
         cmt_d = cmt_q + cmt_add_s;
      end

      // Flush sees this cycle's commits first, then drops everything younger.
      if (sb.flush) begin
         tail_d = cmt_d;
      end else if (enq_s) begin
         tail_d = tail_q + PTR_ONE;
      end else begin
         tail_d = tail_q;
      end

      if (drain_s) begin
         head_d = head_q + PTR_ONE;
      end else begin
         head_d = head_q;
      end
   end

   // Pointer and entry registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
         for (int i = 0; i < SB_DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         head_q    <= head_d;
         cmt_q     <= cmt_d;
         tail_q    <= tail_d;
         entries_q <= entries_d;
      end
   end

   // All outputs below depend on registers only (ld_conflict also on ld_addr).
   assign sb.dcache_wr_req   = (head_q != cmt_q);
   assign sb.dcache_wr_addr  = head_entry_s.addr;
   assign sb.dcache_wr_data  = head_entry_s.data;
   assign sb.dcache_wr_wstrb = head_entry_s.wstrb;
   assign sb.sb_allowin      = allowin_s;
   assign sb.sb_empty        = (head_q == tail_q);

   sb_cam_match #(
      .DEPTH (SB_DEPTH)
   ) u_cam (
      .entries  (entries_q),
      .head_idx (head_q[IDX_W-1:0]),
      .count    (count_s),
      .ld_addr  (sb.ld_addr),
      .hit      (sb.ld_conflict)
   );

   store_buffer_chk #(
      .PTR_W (PTR_W)
   ) u_chk (
      .clk        (clk),
      .reset      (reset),
      .st_valid   (sb.st_valid),
      .sb_allowin (allowin_s),
      .commit1    (sb.commit_store1_valid),
      .commit2    (sb.commit_store2_valid),
      .spec_cnt   (spec_cnt_s)
   );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected dcache writes are queued when a store is
// enqueued, trimmed on flush, and popped/compared on every dcache handshake.
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic clk;
   logic reset;
   store_buffer_if sbif ();

   store_buffer #(.SB_DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int        n_tests   = 0;
   int        n_fail    = 0;
   int        n_drained = 0;
   sb_entry_t exp_q [$];

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; a handshake seen before the edge is checked against the scoreboard.
   task automatic tick();
      sb_entry_t e;
      @(negedge clk);
      if (sbif.dcache_wr_req === 1'b1 && sbif.dcache_wr_ready === 1'b1) begin
         chk("drain_expected", 68'(exp_q.size() != 0), 68'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_drained++;
            chk("drain_order", {sbif.dcache_wr_addr, sbif.dcache_wr_data, sbif.dcache_wr_wstrb},
                {e.addr, e.data, e.wstrb});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      sbif.st_valid = 1'b1;
      sbif.st_addr  = a;
      sbif.st_data  = d;
      sbif.st_wstrb = s;
      tick();
      sbif.st_valid = 1'b0;
      exp_q.push_back('{addr: a, data: d, wstrb: s});
   endtask

   task automatic commit(input logic c1, input logic c2);
      sbif.commit_store1_valid = c1;
      sbif.commit_store2_valid = c2;
      tick();
      sbif.commit_store1_valid = 1'b0;
      sbif.commit_store2_valid = 1'b0;
   endtask

   task automatic drain_all();
      for (int i = 0; i < 30 && sbif.sb_empty !== 1'b1; i++) tick();
   endtask

   initial begin
      reset                    = 1'b1;
      sbif.flush               = 1'b0;
      sbif.st_valid            = 1'b0;
      sbif.st_addr             = 32'h0;
      sbif.st_data             = 32'h0;
      sbif.st_wstrb            = 4'h0;
      sbif.st_ex               = 1'b0;
      sbif.commit_store1_valid = 1'b0;
      sbif.commit_store2_valid = 1'b0;
      sbif.dcache_wr_ready     = 1'b0;
      sbif.ld_addr             = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_req",      68'(sbif.dcache_wr_req), 68'd0);
      chk("rst_conflict", 68'(sbif.ld_conflict),   68'd0);
      chk("rst_allowin",  68'(sbif.sb_allowin),    68'd1);
      chk("rst_empty",    68'(sbif.sb_empty),      68'd1);

      // 1: three stores, commit 2 then 1, drain in order
      enq(32'h100, 32'hAAAA_0001, 4'hF);
      enq(32'h104, 32'hAAAA_0002, 4'hF);
      enq(32'h108, 32'hAAAA_0003, 4'h3);
      chk("t1_spec_no_req", 68'(sbif.dcache_wr_req), 68'd0);
      commit(1'b1, 1'b1);
      chk("t1_req_after_commit", 68'(sbif.dcache_wr_req), 68'd1);
      commit(1'b1, 1'b0);
      sbif.dcache_wr_ready = 1'b1;
      n_drained = 0;
      drain_all();
      chk("t1_drained", 68'(n_drained), 68'd3);
      chk("t1_empty",   68'(sbif.sb_empty), 68'd1);

      // 2: fill all 8, full stops allowin; commit all, drain across the wrap
      sbif.dcache_wr_ready = 1'b0;
      for (int i = 0; i < 8; i++) enq(32'h1000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'hF);
      chk("t2_full_allowin", 68'(sbif.sb_allowin), 68'd0);
      for (int i = 0; i < 4; i++) commit(1'b1, 1'b1);
      chk("t2_still_full", 68'(sbif.sb_allowin), 68'd0);
      sbif.dcache_wr_ready = 1'b1;
      n_drained = 0;
      tick();
      chk("t2_allowin_after_drain", 68'(sbif.sb_allowin), 68'd1);
      drain_all();
      chk("t2_drained", 68'(n_drained), 68'd8);

      // 3: four stores, commit two, flush (with an ignored enqueue), then a new store
      sbif.dcache_wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) enq(32'h300 + 32'(4 * i), 32'h3300_0000 + 32'(i), 4'hF);
      commit(1'b1, 1'b1);
      sbif.flush    = 1'b1;
      sbif.st_valid = 1'b1;
      sbif.st_addr  = 32'h500;
      sbif.st_data  = 32'h5555_5555;
      sbif.st_wstrb = 4'hF;
      tick();
      sbif.flush    = 1'b0;
      sbif.st_valid = 1'b0;
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      chk("t3_req_kept", 68'(sbif.dcache_wr_req), 68'd1);
      enq(32'h400, 32'h4444_0000, 4'hC);
      commit(1'b1, 1'b0);
      sbif.dcache_wr_ready = 1'b1;
      n_drained = 0;
      drain_all();
      chk("t3_drained", 68'(n_drained), 68'd3);
      chk("t3_empty",   68'(sbif.sb_empty), 68'd1);
      chk("t3_queue",   68'(exp_q.size()), 68'd0);

      // 4: committed head held stable while ready is low
      sbif.dcache_wr_ready = 1'b0;
      enq(32'h600, 32'h6666_0606, 4'hF);
      commit(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold", {sbif.dcache_wr_req, sbif.dcache_wr_addr, sbif.dcache_wr_data},
             {1'b1, 32'h600, 32'h6666_0606});
      end
      sbif.dcache_wr_ready = 1'b1;
      n_drained = 0;
      tick();
      chk("t4_pop", 68'(n_drained), 68'd1);
      chk("t4_empty", 68'(sbif.sb_empty), 68'd1);

      // 5: load conflict lookup
      sbif.dcache_wr_ready = 1'b0;
      enq(32'h200, 32'h0000_BEEF, 4'b0011);
      sbif.ld_addr = 32'h202; #1;
      chk("t5_same_word", 68'(sbif.ld_conflict), 68'd1);
      sbif.ld_addr = 32'h204; #1;
      chk("t5_next_word", 68'(sbif.ld_conflict), 68'd0);
      sbif.ld_addr = 32'h1FC; #1;
      chk("t5_prev_word", 68'(sbif.ld_conflict), 68'd0);
      commit(1'b1, 1'b0);
      sbif.ld_addr = 32'h200; #1;
      chk("t5_committed", 68'(sbif.ld_conflict), 68'd1);
      sbif.dcache_wr_ready = 1'b1;
      drain_all();
      sbif.ld_addr = 32'h202; #1;
      chk("t5_after_drain", 68'(sbif.ld_conflict), 68'd0);

      // 6: excepting store is dropped; reset clears a waiting committed entry
      sbif.dcache_wr_ready = 1'b0;
      sbif.st_valid = 1'b1;
      sbif.st_ex    = 1'b1;
      sbif.st_addr  = 32'h6FC;
      tick();
      sbif.st_valid = 1'b0;
      sbif.st_ex    = 1'b0;
      chk("t6_ex_empty", 68'(sbif.sb_empty), 68'd1);
      enq(32'h700, 32'h7777_0000, 4'hF);
      commit(1'b1, 1'b0);
      chk("t6_req_waiting", {sbif.dcache_wr_req, sbif.dcache_wr_addr}, {1'b1, 32'h700});
      reset = 1'b1;
      tick();
      exp_q.delete();
      chk("t6_rst_req",     68'(sbif.dcache_wr_req), 68'd0);
      chk("t6_rst_empty",   68'(sbif.sb_empty),      68'd1);
      chk("t6_rst_allowin", 68'(sbif.sb_allowin),    68'd1);
      reset = 1'b0;
      tick();
      chk("t6_post_rst_req", 68'(sbif.dcache_wr_req), 68'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
